// File: rtl/video_pkg.sv
// Shared types and constants for the camera video stream blocks.
package video_pkg;

  localparam int unsigned VID_DW    = 24;
  localparam int unsigned VID_LINES = 720;
  localparam int unsigned VID_LCW   = 10;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // One video beat as carried on an AXI4-Stream video port.
  typedef struct packed {
    logic [VID_DW-1:0] tdata;
    logic              tlast;
    logic              tuser;
  } vid_beat_t;

endpackage

// File: rtl/axis_video_reg_slice.sv
// One-deep valid/ready register slice for a packed {tdata, tlast, tuser} payload.
module axis_video_reg_slice #(
  parameter int unsigned PW = 26
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid_i,
  output logic          s_ready_c,
  input  logic [PW-1:0] s_data_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [PW-1:0] m_data_o
);

  logic          valid_q;
  logic [PW-1:0] data_q;

  // Accept whenever the slot is empty or is being drained this cycle.
  assign s_ready_c = !valid_q || m_ready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (s_ready_c) begin
      valid_q <= s_valid_i;
      if (s_valid_i) begin
        data_q <= s_data_i;
      end
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;

endmodule

// File: rtl/video_frame_arbiter.sv
// Frame-granular round-robin 2:1 arbiter feeding the shared YCbCr-to-RGB converter.
module video_frame_arbiter
  import video_pkg::*;
#(
  parameter int unsigned DW    = VID_DW,
  parameter int unsigned LINES = VID_LINES,
  parameter int unsigned LCW   = VID_LCW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [DW-1:0] s0_axis_video_tdata,
  input  logic          s0_axis_video_tvalid,
  output logic          s0_axis_video_tready,
  input  logic          s0_axis_video_tlast,
  input  logic          s0_axis_video_tuser,
  input  logic [DW-1:0] s1_axis_video_tdata,
  input  logic          s1_axis_video_tvalid,
  output logic          s1_axis_video_tready,
  input  logic          s1_axis_video_tlast,
  input  logic          s1_axis_video_tuser,
  output logic [DW-1:0] m_axis_video_tdata,
  output logic          m_axis_video_tvalid,
  input  logic          m_axis_video_tready,
  output logic          m_axis_video_tlast,
  output logic          m_axis_video_tuser,
  output logic          grant,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    sof_err_cnt
);

  localparam int unsigned PW = DW + 2;

  state_e         state_q, state_d;
  logic           grant_q, grant_d;
  logic [LCW-1:0] line_q, line_d;
  logic [7:0]     err_q, err_d;
  logic           done_q, done_d;

  logic           slot_free_c;
  logic [1:0]     sof_c;
  logic           sel_valid_c, sel_last_c, sel_user_c;
  logic [DW-1:0]  sel_data_c;
  logic           acc_c;
  logic [PW-1:0]  m_data;

  assign sof_c = {s1_axis_video_tvalid && s1_axis_video_tuser,
                  s0_axis_video_tvalid && s0_axis_video_tuser};

  assign sel_valid_c = grant_q ? s1_axis_video_tvalid : s0_axis_video_tvalid;
  assign sel_data_c  = grant_q ? s1_axis_video_tdata  : s0_axis_video_tdata;
  assign sel_last_c  = grant_q ? s1_axis_video_tlast  : s0_axis_video_tlast;
  assign sel_user_c  = grant_q ? s1_axis_video_tuser  : s0_axis_video_tuser;
  assign acc_c       = (state_q == STREAM) && sel_valid_c && slot_free_c;

  // Arbitration, frame tracking and per-source ready generation.
  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    line_d               = line_q;
    err_d                = err_q;
    done_d               = 1'b0;
    s0_axis_video_tready = 1'b0;
    s1_axis_video_tready = 1'b0;
    case (state_q)
      IDLE: begin
        // Non-SOF beats are swallowed so a source resyncs on its next frame start.
        s0_axis_video_tready = s0_axis_video_tvalid && !s0_axis_video_tuser;
        s1_axis_video_tready = s1_axis_video_tvalid && !s1_axis_video_tuser;
        if (en && (sof_c != 2'b00)) begin
          state_d = STREAM;
          grant_d = (sof_c == 2'b11) ? !grant_q : sof_c[1];
        end
      end
      STREAM: begin
        s0_axis_video_tready = !grant_q && slot_free_c;
        s1_axis_video_tready = grant_q && slot_free_c;
        if (acc_c) begin
          if (sel_user_c && (line_q != '0)) begin
            line_d = '0;
            if (err_q != 8'hff) begin
              err_d = err_q + 8'd1;
            end
          end else if (sel_last_c && (line_q == LCW'(LINES - 1))) begin
            line_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (sel_last_c) begin
            line_d = line_q + LCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      line_q  <= '0;
      err_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      line_q  <= line_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  axis_video_reg_slice #(
    .PW (PW)
  ) u_out_slice (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid_i (acc_c),
    .s_ready_c (slot_free_c),
    .s_data_i  ({sel_data_c, sel_last_c, sel_user_c}),
    .m_valid_o (m_axis_video_tvalid),
    .m_ready_i (m_axis_video_tready),
    .m_data_o  (m_data)
  );

  assign m_axis_video_tdata = m_data[PW-1:2];
  assign m_axis_video_tlast = m_data[1];
  assign m_axis_video_tuser = m_data[0];

  assign grant       = grant_q;
  assign busy        = (state_q == STREAM);
  assign frame_done  = done_q;
  assign sof_err_cnt = err_q;

endmodule

// File: tb/tb_video_frame_arbiter.sv
// Scoreboard bench for video_frame_arbiter with 2-line, 4-pixel frames.
module tb_video_frame_arbiter;
  import video_pkg::*;

  localparam int unsigned DW    = VID_DW;
  localparam int unsigned LINES = 2;
  localparam int unsigned LCW   = 2;
  localparam int          NPX   = 4;
  localparam int          TMO   = 200;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          en;
  logic [DW-1:0] s0_d, s1_d, m_d;
  logic          s0_v, s0_r, s0_l, s0_u;
  logic          s1_v, s1_r, s1_l, s1_u;
  logic          m_v, m_r, m_l, m_u;
  logic          grant, busy, frame_done;
  logic [7:0]    sof_err_cnt;

  int        total = 0;
  int        bad = 0;
  int        fd_cnt = 0;
  int        exp_err;
  bit        excl_on = 1'b0;
  bit        rdy_on = 1'b0;
  bit        stalled = 1'b0;
  vid_beat_t hold_b;
  vid_beat_t m_beat;
  vid_beat_t exp_q[$];

  assign m_beat = {m_d, m_l, m_u};

  always #5 clk = ~clk;

  video_frame_arbiter #(.DW(DW), .LINES(LINES), .LCW(LCW)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .en                   (en),
    .s0_axis_video_tdata  (s0_d),
    .s0_axis_video_tvalid (s0_v),
    .s0_axis_video_tready (s0_r),
    .s0_axis_video_tlast  (s0_l),
    .s0_axis_video_tuser  (s0_u),
    .s1_axis_video_tdata  (s1_d),
    .s1_axis_video_tvalid (s1_v),
    .s1_axis_video_tready (s1_r),
    .s1_axis_video_tlast  (s1_l),
    .s1_axis_video_tuser  (s1_u),
    .m_axis_video_tdata   (m_d),
    .m_axis_video_tvalid  (m_v),
    .m_axis_video_tready  (m_r),
    .m_axis_video_tlast   (m_l),
    .m_axis_video_tuser   (m_u),
    .grant                (grant),
    .busy                 (busy),
    .frame_done           (frame_done),
    .sof_err_cnt          (sof_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pix(input int src, input int fid, input int k);
    return DW'((src << 20) | (fid << 12) | (k & 'hfff));
  endfunction

  function automatic logic rdy(input int src);
    return (src == 0) ? s0_r : s1_r;
  endfunction

  task automatic drive(input int src, input logic v, input logic [DW-1:0] d,
                       input logic l, input logic u);
    if (src == 0) begin
      s0_v = v; s0_d = d; s0_l = l; s0_u = u;
    end else begin
      s1_v = v; s1_d = d; s1_l = l; s1_u = u;
    end
  endtask

  // Present one beat from posedge+1 and hold it until a handshake is seen.
  task automatic send_beat(input int src, input logic [DW-1:0] d, input logic l, input logic u);
    int n = 0;
    drive(src, 1'b1, d, l, u);
    forever begin
      @(negedge clk);
      if (rdy(src)) break;
      n++;
      if (n >= TMO) begin
        chk("beat_timeout", 32'(0), 32'(1));
        break;
      end
    end
    sync();
    drive(src, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic sb(input int src, input logic [DW-1:0] d, input logic l, input logic u);
    exp_q.push_back({d, l, u});
    send_beat(src, d, l, u);
  endtask

  task automatic exp_frame(input int src, input int fid);
    for (int ln = 0; ln < int'(LINES); ln++)
      for (int px = 0; px < NPX; px++)
        exp_q.push_back({pix(src, fid, ln * NPX + px), px == NPX - 1, (ln == 0) && (px == 0)});
  endtask

  task automatic send_frame(input int src, input int fid);
    for (int ln = 0; ln < int'(LINES); ln++)
      for (int px = 0; px < NPX; px++)
        send_beat(src, pix(src, fid, ln * NPX + px), px == NPX - 1, (ln == 0) && (px == 0));
  endtask

  // Output monitor: scoreboard pop, stall stability, ready and exclusivity checks.
  always @(negedge clk) begin
    if (rstn) begin
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (stalled) begin
        chk("m_hold_valid", 32'(m_v), 32'(1));
        chk("m_hold_data", 32'(m_beat), 32'(hold_b));
      end
      stalled <= m_v && !m_r;
      hold_b  <= m_beat;
      if (m_v && m_r) begin
        if (exp_q.size() == 0) begin
          chk("m_extra", 32'(m_beat), 32'hffff_ffff);
        end else begin
          chk("m_beat", 32'(m_beat), 32'(exp_q[0]));
          if (exp_q[0].tuser) chk("sof_grant", 32'(grant), 32'(exp_q[0].tdata[20]));
          void'(exp_q.pop_front());
        end
      end
      if (excl_on && busy) chk("excl_rdy", 32'(s0_r & s1_r), 32'(0));
      if (rdy_on && busy) chk("rdy_slot", 32'(grant ? s1_r : s0_r), 32'(!m_v || m_r));
    end else begin
      stalled <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    m_r = 1'b1;
    en  = 1'b1;
    #1 rstn = 1'b0;
    #2;
    chk("rst_grant", 32'(grant), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_mvalid", 32'(m_v), 32'(0));
    chk("rst_fd", 32'(frame_done), 32'(0));
    chk("rst_err", 32'(sof_err_cnt), 32'(0));
    @(negedge clk);
    rstn = 1'b1;
    sync();

    // Single-source frame on s0.
    exp_frame(0, 1);
    send_frame(0, 1);
    @(negedge clk);
    chk("t1_fd", 32'(frame_done), 32'(1));
    chk("t1_busy", 32'(busy), 32'(0));
    chk("t1_grant", 32'(grant), 32'(0));
    @(negedge clk);
    chk("t1_fd_pulse", 32'(frame_done), 32'(0));
    chk("t1_drained", 32'(exp_q.size()), 32'(0));
    sync();

    // Non-SOF beats while idle are accepted and dropped.
    for (int i = 0; i < 3; i++) send_beat(1, pix(1, 9, i), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t3_mvalid", 32'(m_v), 32'(0));
    chk("t3_busy", 32'(busy), 32'(0));
    sync();

    // s1 alone, so grant ends at 1 before the contended rounds.
    exp_frame(1, 2);
    send_frame(1, 2);
    repeat (2) @(negedge clk);
    chk("s1_grant", 32'(grant), 32'(1));
    sync();

    // Both sources contend: expected order s0, s1, s0, then s1 alone.
    excl_on = 1'b1;
    exp_frame(0, 3); exp_frame(1, 3); exp_frame(0, 4); exp_frame(1, 4);
    fork
      begin send_frame(0, 3); send_frame(0, 4); end
      begin send_frame(1, 3); send_frame(1, 4); end
    join
    repeat (2) @(negedge clk);
    excl_on = 1'b0;
    chk("t2_frames", 32'(fd_cnt), 32'(6));
    chk("t2_drained", 32'(exp_q.size()), 32'(0));
    sync();

    // Downstream back-pressure pattern 1,0,0,1.
    rdy_on = 1'b1;
    exp_frame(0, 5);
    fork
      send_frame(0, 5);
      begin
        for (int k = 0; k < 16; k++) begin
          sync();
          m_r = ((k % 4) == 0) || ((k % 4) == 3);
        end
        m_r = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    rdy_on = 1'b0;
    chk("t4_drained", 32'(exp_q.size()), 32'(0));
    chk("t4_frames", 32'(fd_cnt), 32'(7));
    sync();

    // Mid-frame SOF restarts the line count.
    sb(0, pix(0, 6, 0), 1'b0, 1'b1);
    sb(0, pix(0, 6, 1), 1'b1, 1'b0);
    sb(0, pix(0, 6, 2), 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_err1", 32'(sof_err_cnt), 32'(1));
    sync();
    sb(0, pix(0, 6, 3), 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_still_busy", 32'(busy), 32'(1));
    sync();
    sb(0, pix(0, 6, 4), 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_fd", 32'(frame_done), 32'(1));
    sync();

    // Saturation of the mid-frame SOF counter.
    exp_err = 1;
    sb(0, pix(0, 7, 0), 1'b1, 1'b1);
    for (int i = 0; i < 299; i++) begin
      sb(0, pix(0, 7, 2 * i + 1), 1'b0, 1'b1);
      exp_err = (exp_err == 255) ? 255 : exp_err + 1;
      sb(0, pix(0, 7, 2 * i + 2), 1'b1, 1'b0);
      if (i == 0 || i == 252 || i == 253 || i == 298) begin
        @(negedge clk);
        chk("t5_sat", 32'(sof_err_cnt), 32'(exp_err));
        sync();
      end
    end
    sb(0, pix(0, 7, 600), 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_sat_fd", 32'(frame_done), 32'(1));
    sync();

    // en falling mid-frame lets the frame finish, then blocks new grants.
    exp_frame(0, 8);
    fork
      send_frame(0, 8);
      begin repeat (3) sync(); en = 1'b0; end
    join
    @(negedge clk);
    chk("t6_fd", 32'(frame_done), 32'(1));
    sync();
    exp_frame(0, 9);
    fork
      send_frame(0, 9);
      begin
        repeat (5) @(negedge clk);
        chk("t6_hold_busy", 32'(busy), 32'(0));
        chk("t6_hold_rdy", 32'(s0_r), 32'(0));
        sync();
        en = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    chk("t6_drained", 32'(exp_q.size()), 32'(0));
    chk("t6_grant", 32'(grant), 32'(0));
    sync();

    // Asynchronous reset in the middle of a frame with a stalled output.
    sb(0, pix(0, 10, 0), 1'b0, 1'b1);
    sb(0, pix(0, 10, 1), 1'b0, 1'b0);
    sb(0, pix(0, 10, 2), 1'b0, 1'b0);
    m_r = 1'b0;
    #2;
    chk("t7_pre_busy", 32'(busy), 32'(1));
    chk("t7_pre_mvalid", 32'(m_v), 32'(1));
    rstn = 1'b0;
    #1;
    chk("t7_mvalid", 32'(m_v), 32'(0));
    chk("t7_mdata", 32'(m_d), 32'(0));
    chk("t7_busy", 32'(busy), 32'(0));
    chk("t7_grant", 32'(grant), 32'(1));
    chk("t7_fd", 32'(frame_done), 32'(0));
    chk("t7_err", 32'(sof_err_cnt), 32'(0));
    exp_q.delete();
    m_r = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    sync();

    // Recovery after reset.
    exp_frame(0, 11);
    send_frame(0, 11);
    repeat (2) @(negedge clk);
    chk("t8_grant", 32'(grant), 32'(0));
    chk("t8_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_frame_arbiter.md
Name: video_frame_arbiter

Overview:
- Frame-granular 2:1 arbiter that shares the single YCbCr-to-RGB converter between two camera AXI4-Stream video sources.
- Sits directly upstream of the converter's s_axis_video port.
- Grants one source for a whole frame, from the tuser beat to the final tlast beat, then re-arbitrates round-robin.
- Discards beats from an ungranted source that are not frame-aligned, so the converter only ever sees whole frames.

Parameters:
- DW, 24, video data width (packed Cr,Cb,Y, 8 bits each).
- LINES, 720, number of tlast beats that make up one frame.
- LCW, 10, line counter width; must satisfy 2^LCW >= LINES.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  1 = new grants allowed; 0 = the frame in progress completes and no new grant is issued.
- s0_axis_video_tdata  in  DW  source 0 pixel.
- s0_axis_video_tvalid  in  1  source 0 valid.
- s0_axis_video_tready  out  1  source 0 ready.
- s0_axis_video_tlast  in  1  source 0 end of line.
- s0_axis_video_tuser  in  1  source 0 start of frame.
- s1_axis_video_*  same five signals, same directions and widths, for source 1.
- m_axis_video_tdata  out  DW  to converter.
- m_axis_video_tvalid  out  1  to converter.
- m_axis_video_tready  in  1  from converter.
- m_axis_video_tlast  out  1  to converter.
- m_axis_video_tuser  out  1  to converter.
- grant  out  1  source currently or last granted.
- busy  out  1  state is STREAM.
- frame_done  out  1  one-cycle pulse when a frame's final beat is accepted from the granted source.
- sof_err_cnt  out  8  saturating count of mid-frame tuser beats.

Behaviour:
- Reset values:
  - All outputs are 0, except grant = 1, so source 0 wins the first arbitration.
  - state = IDLE, line_cnt = 0, output register empty.
- Handshake:
  - All transfers are AXI4-Stream; a beat moves when tvalid && tready.
  - Once m_axis_video_tvalid is asserted, it and the m payload are held stable until m_axis_video_tready.
- Output stage:
  - One register slice; latency is 1 cycle from the input handshake to m_axis_video_tvalid.
  - slot_free = !m_axis_video_tvalid || m_axis_video_tready.
  - In STREAM: s<grant>_tready = slot_free; the other source's tready = 0 (held).
- State IDLE:
  - Any input with tvalid && !tuser gets tready = 1 and the beat is dropped (resync to frame start).
  - Inputs with tvalid && tuser get tready = 0 and are held.
  - If en = 1 and exactly one source presents tvalid && tuser, grant that source.
  - If both present, grant = !grant (round-robin).
  - On a grant: update grant, go to STREAM. The SOF beat is accepted in the following cycle. No beat is accepted in the grant cycle.
  - If en = 0: only dropping occurs.
- State STREAM, on each accepted beat from the granted source:
  - Copy data, tlast and tuser into the output register.
  - tuser && line_cnt != 0: increment sof_err_cnt (saturate at 255), line_cnt = 0, stay in STREAM, beat forwarded.
  - tlast && line_cnt == LINES-1: line_cnt = 0, pulse frame_done, go to IDLE.
  - Other tlast: line_cnt += 1.
- en falling mid-frame has no effect until the frame ends.
- A granted source that stalls (tvalid = 0) keeps the grant indefinitely; there is no timeout.
- The output register drains independently of state; return to IDLE does not flush it.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost and the downstream converter also resets.
- busy = (state == STREAM).

Decomposition:
- Shared package video_pkg holds:
  - state enum {IDLE, STREAM};
  - VID_DW = 24;
  - the default LINES constant.
- One sub-module, axis_video_reg_slice: 1-deep register with valid/ready and payload {tdata, tlast, tuser}. It is reused by other stream blocks.

Test Plan:
- Reset, then 2-line frame (LINES=2) on s0 only, 4 px/line, m_tready = 1 -> grant = 0; 8 beats out, in order, tuser on beat 0, tlast on beats 3 and 7; frame_done pulse 1 cycle after beat 7 is accepted; returns to IDLE.
- Both sources present SOF in the same cycle, three times -> frames granted s0, s1, s0; other source's tready stays 0 throughout each frame.
- s1 sends 3 non-SOF beats while IDLE -> all three accepted (tready = 1) and dropped; none appear on m.
- m_tready toggles 1,0,0,1 mid-line -> m payload stable during stall; no beat lost or duplicated; s tready follows slot_free.
- tuser asserted at line 1 of the granted frame -> sof_err_cnt 0->1; line_cnt restarts; frame ends after LINES further tlasts; sof_err_cnt saturates at 255 after 300 such events.
- en dropped mid-frame -> current frame completes with frame_done; s0 SOF pending afterwards is not granted until en = 1. rstn pulsed mid-frame -> outputs return to reset values on the next observation, without waiting for a clock edge.
